cell_bitmap_capture: RTL and testbench

- Upstream stage of the handwritten-digit input path.
- Deserialises a raster pixel stream of one 52x52 Sudoku cell into a thresholded 1-bit bitmap.
- Presents the bitmap, held stable, as the 2704-bit raw cell image consumed by the 52-to-28 downsampling stage that feeds the classifier.
- Accepts one frame, holds it until the consumer acknowledges, then accepts the next.

---
 rtl/cell_bitmap_capture.sv | 167 ++++++++++++++++
 tb/tb_cell_bitmap_capture.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cell_bitmap_capture.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// cell_bitmap_capture
//
// Deserialises the raster pixel stream of one RAW_SIZE x RAW_SIZE Sudoku cell
// into a thresholded 1-bit bitmap. The finished bitmap is held stable for the
// downsampling stage until it is acknowledged. Only then is the next frame
// accepted.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   pix_valid    pixel beat valid
//   pix_ready    block can accept a beat (low only while a frame is held)
//   pix_sof      beat is pixel (0,0) of a frame
//   pix_data     grayscale pixel value
//   frame_valid  raw_bitmap holds a complete frame
//   frame_ack    consumer has taken the frame
//   raw_bitmap   bit row*RAW_SIZE+col = 1 for ink, row-major
//   frame_err    one-cycle pulse when a frame restarts before completion
//
// Optional feature (macro CELL_BBOX_EN):
//   bbox_min_row / bbox_max_row / bbox_min_col / bbox_max_col / bbox_empty
//   give the bounding box of the ink pixels in the current frame.
// -----------------------------------------------------------------------------
module cell_bitmap_capture #(
   parameter int RAW_SIZE = 52,
   parameter int PIX_W    = 8,
   parameter int THRESH   = 128,
   parameter int INVERT   = 0
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           pix_valid,
   output logic                           pix_ready,
   input  logic                           pix_sof,
   input  logic [PIX_W-1:0]               pix_data,
   output logic                           frame_valid,
   input  logic                           frame_ack,
   output logic [RAW_SIZE*RAW_SIZE-1:0]   raw_bitmap,
   output logic                           frame_err
`ifdef CELL_BBOX_EN
   ,
   output logic [$clog2(RAW_SIZE)-1:0]    bbox_min_row,
   output logic [$clog2(RAW_SIZE)-1:0]    bbox_max_row,
   output logic [$clog2(RAW_SIZE)-1:0]    bbox_min_col,
   output logic [$clog2(RAW_SIZE)-1:0]    bbox_max_col,
   output logic                           bbox_empty
`endif
);

   localparam int CNT_W = $clog2(RAW_SIZE);
   localparam int NPIX  = RAW_SIZE * RAW_SIZE;
   localparam int IDX_W = $clog2(NPIX);
   localparam logic [CNT_W-1:0] LAST     = CNT_W'(RAW_SIZE - 1);
   localparam logic [PIX_W-1:0] THRESH_V = PIX_W'(THRESH);

   typedef enum logic [1:0] {
      IDLE,
      CAPTURE,
      DONE
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   row;
   logic [CNT_W-1:0]   col;
   logic               accept;
   logic               ink;
   logic               last_pix;
   logic [IDX_W-1:0]   wr_idx;

   assign pix_ready = (state != DONE);
   assign accept    = pix_valid && pix_ready;
   assign ink       = (INVERT != 0) ? (pix_data < THRESH_V) : (pix_data >= THRESH_V);
   assign last_pix  = (row == LAST) && (col == LAST);
   assign wr_idx    = IDX_W'(row) * IDX_W'(RAW_SIZE) + IDX_W'(col);

   // Capture FSM. row/col always point at the pixel the next beat belongs to.
   // A sof beat always becomes pixel (0,0), so a sof seen mid-capture simply
   // restarts the frame and flags it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         row         <= '0;
         col         <= '0;
         raw_bitmap  <= '0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         case (state)
            IDLE: begin
               if (accept && pix_sof) begin
                  raw_bitmap[0] <= ink;
                  row           <= '0;
                  col           <= CNT_W'(1);
                  state         <= CAPTURE;
               end
            end
            CAPTURE: begin
               if (accept) begin
                  if (pix_sof) begin
                     raw_bitmap[0] <= ink;
                     row           <= '0;
                     col           <= CNT_W'(1);
                     frame_err     <= 1'b1;
                  end else begin
                     raw_bitmap[wr_idx] <= ink;
                     if (last_pix) begin
                        row         <= '0;
                        col         <= '0;
                        frame_valid <= 1'b1;
                        state       <= DONE;
                     end else if (col == LAST) begin
                        col <= '0;
                        row <= row + CNT_W'(1);
                     end else begin
                        col <= col + CNT_W'(1);
                     end
                  end
               end
            end
            DONE: begin
               if (frame_ack && frame_valid) begin
                  frame_valid <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef CELL_BBOX_EN
   logic bbox_start;
   logic bbox_beat;

   // Frame starts are exactly the beats that the FSM writes as pixel (0,0).
   assign bbox_start = accept && pix_sof;
   assign bbox_beat  = accept && !pix_sof && (state == CAPTURE);

   // Bounding box tracker. The start beat is itself pixel (0,0), so when it is
   // ink the box is seeded at (0,0) rather than left empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bbox_min_row <= LAST;
         bbox_max_row <= '0;
         bbox_min_col <= LAST;
         bbox_max_col <= '0;
         bbox_empty   <= 1'b1;
      end else if (bbox_start) begin
         bbox_min_row <= ink ? '0 : LAST;
         bbox_max_row <= '0;
         bbox_min_col <= ink ? '0 : LAST;
         bbox_max_col <= '0;
         bbox_empty   <= !ink;
      end else if (bbox_beat && ink) begin
         if (row < bbox_min_row) bbox_min_row <= row;
         if (row > bbox_max_row) bbox_max_row <= row;
         if (col < bbox_min_col) bbox_min_col <= col;
         if (col > bbox_max_col) bbox_max_col <= col;
         bbox_empty <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_cell_bitmap_capture.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_cell_bitmap_capture
//
// Self-checking bench for cell_bitmap_capture with default parameters
// (52x52, threshold 128, no inversion). Frames are built in a pixel buffer,
// streamed into the DUT, and the captured bitmap is compared against a
// threshold of that buffer. Bounding-box outputs are checked when the design
// is built with CELL_BBOX_EN.
// -----------------------------------------------------------------------------
module tb_cell_bitmap_capture;

   localparam int N    = 52;
   localparam int NPIX = N * N;

   logic             clk;
   logic             rst_n;
   logic             pix_valid;
   logic             pix_ready;
   logic             pix_sof;
   logic [7:0]       pix_data;
   logic             frame_valid;
   logic             frame_ack;
   logic [NPIX-1:0]  raw_bitmap;
   logic             frame_err;
`ifdef CELL_BBOX_EN
   logic [5:0]       bbox_min_row;
   logic [5:0]       bbox_max_row;
   logic [5:0]       bbox_min_col;
   logic [5:0]       bbox_max_col;
   logic             bbox_empty;
`endif

   int               total;
   int               bad;
   int               errPulses;
   int               errBase;
   logic [7:0]       frameBuf [0:NPIX-1];
   logic [NPIX-1:0]  expBm;

   cell_bitmap_capture dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pix_valid   (pix_valid),
      .pix_ready   (pix_ready),
      .pix_sof     (pix_sof),
      .pix_data    (pix_data),
      .frame_valid (frame_valid),
      .frame_ack   (frame_ack),
      .raw_bitmap  (raw_bitmap),
      .frame_err   (frame_err)
`ifdef CELL_BBOX_EN
      ,
      .bbox_min_row(bbox_min_row),
      .bbox_max_row(bbox_max_row),
      .bbox_min_col(bbox_min_col),
      .bbox_max_col(bbox_max_col),
      .bbox_empty  (bbox_empty)
`endif
   );

   // 100 MHz clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Count every cycle in which the restart flag is seen high
   always @(negedge clk) begin
      if (rst_n && frame_err) errPulses++;
   end

   // Safety net so the run always ends
   initial begin
      #10_000_000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Reference bitmap: every pixel at or above 128 is ink
   function automatic logic [NPIX-1:0] modelBitmap();
      logic [NPIX-1:0] bm;
      bm = '0;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            bm[r*N + c] = (int'(frameBuf[r*N + c]) >= 128);
      return bm;
   endfunction

   function automatic void fillRandom();
      for (int i = 0; i < NPIX; i++) frameBuf[i] = 8'($urandom_range(0, 255));
      frameBuf[1] = 8'd127;
      frameBuf[2] = 8'd128;
   endfunction

   function automatic void fillBackground();
      for (int i = 0; i < NPIX; i++) frameBuf[i] = 8'($urandom_range(0, 127));
   endfunction

   // Stream the first nBeats pixels of frameBuf, sof on the first one
   task automatic applyStimulus(input int nBeats, input bit gaps, input bit expectRestart);
      for (int i = 0; i < nBeats; i++) begin
         if (gaps && ($urandom_range(0, 3) == 0)) begin
            pix_valid = 1'b0;
            pix_sof   = 1'b0;
            @(posedge clk); #1;
         end
         if (i == NPIX - 1) checkOutput("frame_valid_early", frame_valid, 0);
         pix_valid = 1'b1;
         pix_sof   = (i == 0);
         pix_data  = frameBuf[i];
         @(posedge clk); #1;
         if (i == 0 && expectRestart) checkOutput("frame_err_pulse", frame_err, 1);
      end
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
   endtask

   // Checks made one cycle after the final beat of a completed frame
   task automatic checkFrame(input string name, input int errDelta);
`ifdef CELL_BBOX_EN
      int minR, maxR, minC, maxC, empty;
`endif
      expBm = modelBitmap();
      checkOutput({name, "_frame_valid"}, frame_valid, 1);
      checkOutput({name, "_pix_ready"}, pix_ready, 0);
      checkOutput({name, "_bitmap_diff_bits"}, $countones(raw_bitmap ^ expBm), 0);
      checkOutput({name, "_err_pulses"}, errPulses - errBase, errDelta);
`ifdef CELL_BBOX_EN
      minR = N - 1; maxR = 0; minC = N - 1; maxC = 0; empty = 1;
      for (int i = 0; i < NPIX; i++) begin
         if (int'(frameBuf[i]) >= 128) begin
            if (i / N < minR) minR = i / N;
            if (i / N > maxR) maxR = i / N;
            if (i % N < minC) minC = i % N;
            if (i % N > maxC) maxC = i % N;
            empty = 0;
         end
      end
      checkOutput({name, "_bbox_min_row"}, bbox_min_row, minR);
      checkOutput({name, "_bbox_max_row"}, bbox_max_row, maxR);
      checkOutput({name, "_bbox_min_col"}, bbox_min_col, minC);
      checkOutput({name, "_bbox_max_col"}, bbox_max_col, maxC);
      checkOutput({name, "_bbox_empty"}, bbox_empty, empty);
`endif
   endtask

   // Hold the frame under backpressure with sof beats offered, then ack it
   task automatic ackFrame(input string name, input int holdCycles);
      errBase   = errPulses;
      pix_valid = 1'b1;
      pix_sof   = 1'b1;
      pix_data  = (int'(frameBuf[0]) >= 128) ? 8'd0 : 8'd255;
      repeat (holdCycles) @(posedge clk);
      #1;
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
      checkOutput({name, "_held_bitmap_diff"}, $countones(raw_bitmap ^ expBm), 0);
      checkOutput({name, "_held_valid"}, frame_valid, 1);
      checkOutput({name, "_held_ready"}, pix_ready, 0);
      checkOutput({name, "_held_err"}, errPulses - errBase, 0);
      frame_ack = 1'b1;
      @(posedge clk); #1;
      frame_ack = 1'b0;
      checkOutput({name, "_ack_valid"}, frame_valid, 0);
      checkOutput({name, "_ack_ready"}, pix_ready, 1);
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      errPulses = 0;
      errBase   = 0;
      rst_n     = 1'b0;
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
      pix_data  = 8'd0;
      frame_ack = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_ready", pix_ready, 1);
      checkOutput("reset_valid", frame_valid, 0);
      checkOutput("reset_err", frame_err, 0);
      checkOutput("reset_bitmap_ones", $countones(raw_bitmap), 0);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;

      // Single ink pixel at (10,20), continuous beats
      for (int i = 0; i < NPIX; i++) frameBuf[i] = 8'd0;
      frameBuf[10*N + 20] = 8'd200;
      errBase = errPulses;
      applyStimulus(NPIX, 1'b0, 1'b0);
      checkFrame("single", 0);
      checkOutput("single_bit540", raw_bitmap[540], 1);
      checkOutput("single_ones", $countones(raw_bitmap), 1);
      ackFrame("single", 50);

      // Stray non-sof beats in IDLE are dropped
      errBase = errPulses;
      for (int i = 0; i < 3; i++) begin
         pix_valid = 1'b1;
         pix_sof   = 1'b0;
         pix_data  = 8'($urandom_range(128, 255));
         @(posedge clk); #1;
      end
      pix_valid = 1'b0;
      checkOutput("stray_ready", pix_ready, 1);
      fillRandom();
      applyStimulus(NPIX, 1'b1, 1'b0);
      checkFrame("stray", 0);
      checkOutput("thresh_127", raw_bitmap[1], 0);
      checkOutput("thresh_128", raw_bitmap[2], 1);
      ackFrame("stray", 4);

      // Restart: 101 beats of one frame, then a full second frame
      errBase = errPulses;
      fillRandom();
      applyStimulus(101, 1'b1, 1'b0);
      fillRandom();
      applyStimulus(NPIX, 1'b0, 1'b1);
      checkFrame("restart", 1);
      ackFrame("restart", 2);

      // Asynchronous reset in the middle of capture
      fillRandom();
      applyStimulus(1000, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midreset_bitmap_ones", $countones(raw_bitmap), 0);
      checkOutput("midreset_valid", frame_valid, 0);
      checkOutput("midreset_ready", pix_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      errBase = errPulses;
      fillRandom();
      applyStimulus(NPIX, 1'b1, 1'b0);
      checkFrame("postreset", 0);
      ackFrame("postreset", 1);

      // Three scattered ink pixels
      errBase = errPulses;
      fillBackground();
      frameBuf[5*N + 7]   = 8'd255;
      frameBuf[30*N + 2]  = 8'd128;
      frameBuf[12*N + 40] = 8'd180;
      applyStimulus(NPIX, 1'b0, 1'b0);
      checkFrame("three_ink", 0);
      checkOutput("three_ink_ones", $countones(raw_bitmap), 3);
      ackFrame("three_ink", 1);

      // All-background frame
      errBase = errPulses;
      fillBackground();
      applyStimulus(NPIX, 1'b1, 1'b0);
      checkFrame("blank", 0);
      ackFrame("blank", 1);

      // Random frames with idle gaps
      for (int f = 0; f < 2; f++) begin
         errBase = errPulses;
         fillRandom();
         applyStimulus(NPIX, 1'b1, 1'b0);
         checkFrame("random", 0);
         ackFrame("random", $urandom_range(1, 10));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
